// File: rtl/mode_demux.sv
// Four-channel byte demultiplexer. Each channel has a 1-entry output slot.
// Mode 0 routes bytes by in_dest; mode 1 distributes them round-robin.
// Optional macro MODE_DEMUX_SKIP_BUSY_EN: in mode 1, skip busy slots instead of stalling.
module mode_demux (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic [1:0] in_dest,
    output logic       in_ready,
    output logic [3:0] out_valid,
    output logic [7:0] out_data0,
    output logic [7:0] out_data1,
    output logic [7:0] out_data2,
    output logic [7:0] out_data3,
    input  logic [3:0] out_ready,
    output logic [3:0] route,
    output logic [1:0] rr_ptr
);

    logic [3:0] slot_free;
    logic [1:0] target;
    logic       accept;
    logic [1:0] rr_ptr_q;
    logic [1:0] rr_ptr_d;
    logic [7:0] slot_data [4];

`ifdef MODE_DEMUX_SKIP_BUSY_EN
    // First free slot scanning upward from start; returns start when nothing is free.
    function automatic logic [1:0] first_free(input logic [1:0] start, input logic [3:0] free);
        logic [1:0] idx;
        first_free = start;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (free[idx]) begin
                first_free = idx;
            end
        end
    endfunction
`endif

    always_comb begin
        target   = in_dest;
        in_ready = slot_free[in_dest];
        if (mode) begin
`ifdef MODE_DEMUX_SKIP_BUSY_EN
            target   = first_free(rr_ptr_q, slot_free);
            in_ready = |slot_free;
`else
            target   = rr_ptr_q;
            in_ready = slot_free[rr_ptr_q];
`endif
        end
    end

    assign accept = in_valid && in_ready;
    assign route  = accept ? (4'b0001 << target) : 4'b0000;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (mode && accept) begin
            rr_ptr_d = target + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= 2'd0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign rr_ptr = rr_ptr_q;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_slot
            logic       valid_q;
            logic       valid_d;
            logic [7:0] data_q;
            logic [7:0] data_d;

            // A slot being read out this cycle can take a new byte on the same edge.
            assign slot_free[gi] = !valid_q || out_ready[gi];

            always_comb begin
                valid_d = valid_q;
                data_d  = data_q;
                if (route[gi]) begin
                    valid_d = 1'b1;
                    data_d  = in_data;
                end else if (out_ready[gi]) begin
                    valid_d = 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_q <= 1'b0;
                    data_q  <= 8'h00;
                end else begin
                    valid_q <= valid_d;
                    data_q  <= data_d;
                end
            end

            assign out_valid[gi] = valid_q;
            assign slot_data[gi] = data_q;
        end
    endgenerate

    assign out_data0 = slot_data[0];
    assign out_data1 = slot_data[1];
    assign out_data2 = slot_data[2];
    assign out_data3 = slot_data[3];

endmodule

// File: tb/tb_mode_demux.sv
// Directed self-checking bench for mode_demux; expectations follow the active
// MODE_DEMUX_SKIP_BUSY_EN setting.
module tb_mode_demux;

    logic       clk;
    logic       rst;
    logic       mode;
    logic       in_valid;
    logic [7:0] in_data;
    logic [1:0] in_dest;
    logic       in_ready;
    logic [3:0] out_valid;
    logic [7:0] out_data0;
    logic [7:0] out_data1;
    logic [7:0] out_data2;
    logic [7:0] out_data3;
    logic [3:0] out_ready;
    logic [3:0] route;
    logic [1:0] rr_ptr;
    logic [31:0] all_data;

    int checks = 0;
    int errors = 0;

    mode_demux dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .out_data3 (out_data3),
        .out_ready (out_ready),
        .route     (route),
        .rr_ptr    (rr_ptr)
    );

    assign all_data = {out_data3, out_data2, out_data1, out_data0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_dest = 2'd0; out_ready = 4'b0000;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_dest = 2'd0; out_ready = 4'b0000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL reset_out_valid got %b want 0000", out_valid); end
        checks++; if (rr_ptr !== 2'd0) begin errors++; $display("FAIL reset_rr_ptr got %0d want 0", rr_ptr); end
        checks++; if (all_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 00000000", all_data); end
        checks++; if (route !== 4'b0000) begin errors++; $display("FAIL reset_route got %b want 0000", route); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        $display("reset: out_valid=%b rr_ptr=%0d data=%h", out_valid, rr_ptr, all_data);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_addressed;
        do_reset();
        @(negedge clk);
        mode = 1'b0; out_ready = 4'b0000; in_dest = 2'd2; in_data = 8'hA5; in_valid = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL addr_in_ready got %b want 1", in_ready); end
        checks++; if (route !== 4'b0100) begin errors++; $display("FAIL addr_route got %b want 0100", route); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 4'b0100) begin errors++; $display("FAIL addr_out_valid got %b want 0100", out_valid); end
        checks++; if (all_data !== 32'h00A50000) begin errors++; $display("FAIL addr_data got %h want 00a50000", all_data); end
        $display("addressed: dest=2 data=a5 out_valid=%b out_data2=%h", out_valid, out_data2);
        @(negedge clk);
        in_data = 8'h5A;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL addr_full_in_ready got %b want 0", in_ready); end
        checks++; if (route !== 4'b0000) begin errors++; $display("FAIL addr_full_route got %b want 0000", route); end
        @(posedge clk); #1;
        checks++; if (out_data2 !== 8'hA5) begin errors++; $display("FAIL addr_hold_data got %h want a5", out_data2); end
        checks++; if (rr_ptr !== 2'd0) begin errors++; $display("FAIL addr_rr_ptr got %0d want 0", rr_ptr); end
        $display("addressed: second byte to dest 2 stalled, out_data2=%h", out_data2);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 4'b1111;
        @(posedge clk); #1;
        checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL addr_drain got %b want 0000", out_valid); end
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_route;
        logic [1:0] exp_ptr;
        logic [7:0] byte_v;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            exp_ptr   = 2'(k % 4);
            exp_route = 4'b0001 << (k % 4);
            byte_v    = 8'h10 + 8'(k);
            @(negedge clk);
            mode = 1'b1; out_ready = 4'b1111; in_valid = 1'b1; in_dest = 2'd3; in_data = byte_v;
            #1;
            checks++; if (rr_ptr !== exp_ptr) begin errors++; $display("FAIL rr_ptr[%0d] got %0d want %0d", k, rr_ptr, exp_ptr); end
            checks++; if (route !== exp_route) begin errors++; $display("FAIL rr_route[%0d] got %b want %b", k, route, exp_route); end
            @(posedge clk); #1;
            checks++; if (out_valid !== exp_route) begin errors++; $display("FAIL rr_out_valid[%0d] got %b want %b", k, out_valid, exp_route); end
            checks++; if (all_data[8*(k%4) +: 8] !== byte_v) begin errors++; $display("FAIL rr_data[%0d] got %h want %h", k, all_data[8*(k%4) +: 8], byte_v); end
            $display("round_robin: byte=%h route=%b rr_ptr_before=%0d", byte_v, exp_route, exp_ptr);
        end
        checks++; if (rr_ptr !== 2'd1) begin errors++; $display("FAIL rr_final_ptr got %0d want 1", rr_ptr); end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_skip_busy;
        do_reset();
        @(negedge clk);
        mode = 1'b1; out_ready = 4'b1111; in_valid = 1'b1; in_data = 8'h20;
        @(posedge clk); #1;
        @(negedge clk);
        mode = 1'b0; in_dest = 2'd1; in_data = 8'h21; out_ready = 4'b1101;
        @(posedge clk); #1;
        checks++; if (out_valid !== 4'b0010) begin errors++; $display("FAIL busy_setup_valid got %b want 0010", out_valid); end
        checks++; if (rr_ptr !== 2'd1) begin errors++; $display("FAIL busy_setup_ptr got %0d want 1", rr_ptr); end
        @(negedge clk);
        mode = 1'b1; in_data = 8'h22; in_valid = 1'b1; out_ready = 4'b1101;
        #1;
`ifdef MODE_DEMUX_SKIP_BUSY_EN
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL busy_in_ready got %b want 1", in_ready); end
        checks++; if (route !== 4'b0100) begin errors++; $display("FAIL busy_route got %b want 0100", route); end
        @(posedge clk); #1;
        checks++; if (rr_ptr !== 2'd3) begin errors++; $display("FAIL busy_ptr got %0d want 3", rr_ptr); end
        checks++; if (out_valid !== 4'b0110) begin errors++; $display("FAIL busy_out_valid got %b want 0110", out_valid); end
`else
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL busy_in_ready got %b want 0", in_ready); end
        checks++; if (route !== 4'b0000) begin errors++; $display("FAIL busy_route got %b want 0000", route); end
        @(posedge clk); #1;
        checks++; if (rr_ptr !== 2'd1) begin errors++; $display("FAIL busy_ptr got %0d want 1", rr_ptr); end
        checks++; if (out_valid !== 4'b0010) begin errors++; $display("FAIL busy_out_valid got %b want 0010", out_valid); end
`endif
        $display("skip_busy: rr_ptr=%0d out_valid=%b", rr_ptr, out_valid);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_drain_refill;
        do_reset();
        @(negedge clk);
        mode = 1'b0; in_dest = 2'd0; in_data = 8'h33; in_valid = 1'b1; out_ready = 4'b0000;
        @(posedge clk); #1;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 4'b0001) begin errors++; $display("FAIL dr_hold_valid got %b want 0001", out_valid); end
        checks++; if (out_data0 !== 8'h33) begin errors++; $display("FAIL dr_hold_data got %h want 33", out_data0); end
        @(negedge clk);
        out_ready = 4'b0001; in_data = 8'h7E; in_valid = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL dr_in_ready got %b want 1", in_ready); end
        checks++; if (route !== 4'b0001) begin errors++; $display("FAIL dr_route got %b want 0001", route); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 4'b0001) begin errors++; $display("FAIL dr_valid got %b want 0001", out_valid); end
        checks++; if (out_data0 !== 8'h7E) begin errors++; $display("FAIL dr_data got %h want 7e", out_data0); end
        $display("drain_refill: out_valid=%b out_data0=%h", out_valid, out_data0);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL dr_drain got %b want 0000", out_valid); end
    endtask

    task automatic test_reset_full;
        do_reset();
        @(negedge clk);
        mode = 1'b1; in_valid = 1'b1; in_data = 8'h40; out_ready = 4'b0000;
        @(posedge clk); #1;
        for (int d = 1; d < 4; d++) begin
            @(negedge clk);
            mode = 1'b0; in_dest = 2'(d); in_data = 8'h40 + 8'(d);
            @(posedge clk); #1;
        end
        checks++; if (out_valid !== 4'b1111) begin errors++; $display("FAIL rf_fill_valid got %b want 1111", out_valid); end
        checks++; if (rr_ptr !== 2'd1) begin errors++; $display("FAIL rf_fill_ptr got %0d want 1", rr_ptr); end
        checks++; if (all_data !== 32'h43424140) begin errors++; $display("FAIL rf_fill_data got %h want 43424140", all_data); end
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; mode = 1'b0; in_dest = 2'd0; in_data = 8'h99; out_ready = 4'b1111;
        #1;
        checks++; if (route !== 4'b0001) begin errors++; $display("FAIL rf_route_in_reset got %b want 0001", route); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL rf_valid got %b want 0000", out_valid); end
        checks++; if (all_data !== 32'h0) begin errors++; $display("FAIL rf_data got %h want 00000000", all_data); end
        checks++; if (rr_ptr !== 2'd0) begin errors++; $display("FAIL rf_ptr got %0d want 0", rr_ptr); end
        $display("reset_full: out_valid=%b data=%h rr_ptr=%0d", out_valid, all_data, rr_ptr);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; out_ready = 4'b0000;
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_dest = 2'd0; out_ready = 4'b0000;
        test_reset();
        test_addressed();
        test_round_robin();
        test_skip_busy();
        test_drain_refill();
        test_reset_full();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mode_demux.md
MODE_DEMUX -- requirements
Module: mode_demux

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port mode, input, 1 bit: 0 = addressed routing, 1 = round-robin distribution.
REQ-004 SHALL have port in_valid, input, 1 bit: source offers a byte.
REQ-005 SHALL have port in_data, input, 8 bits: byte offered.
REQ-006 SHALL have port in_dest, input, 2 bits: destination channel, used only in mode 0.
REQ-007 SHALL have port in_ready, output, 1 bit: block accepts in_data this cycle.
REQ-008 SHALL have port out_valid, output, 4 bits: per-channel slot holds a byte.
REQ-009 SHALL have ports out_data0 to out_data3, output, 8 bits each: per-channel slot contents.
REQ-010 SHALL have port out_ready, input, 4 bits: per-channel sink accepts a byte.
REQ-011 SHALL have port route, output, 4 bits: one-hot channel receiving the byte this cycle; 0 when no accept.
REQ-012 SHALL have port rr_ptr, output, 2 bits: current round-robin start channel.

Function
REQ-013 SHALL give each channel i a 1-entry slot (out_valid[i], out_data_i); transfer out occurs when out_valid[i] && out_ready[i].
REQ-014 SHALL treat slot i as free when !out_valid[i] || out_ready[i], so a slot may drain and refill in the same cycle.
REQ-015 SHALL select the target as in_dest in mode 0, and as defined by REQ-023/REQ-024 in mode 1.
REQ-016 SHALL drive in_ready combinationally high exactly when the target slot is free, independent of in_valid.
REQ-017 SHALL define accept as in_valid && in_ready; on accept, the target slot SHALL load in_data, with out_valid set on the next edge, giving 1-cycle latency.
REQ-018 SHALL clear out_valid[i] on a transfer out unless slot i is refilled on the same edge, in which case out_valid[i] stays 1 with the new data.
REQ-019 SHALL hold slot data stable while out_valid[i] && !out_ready[i].
REQ-020 SHALL advance rr_ptr to (target+1) mod 4 on each accept in mode 1, wrapping 3 to 0; rr_ptr SHALL NOT change in mode 0 or without an accept.
REQ-021 SHALL apply a mode change from the next combinational evaluation; occupied slots are unaffected and drain normally.
REQ-022 SHALL make no state change when in_valid=0 and no out_ready transfer occurs.

Reset
REQ-025 SHALL on rst=1 at a clock edge clear out_valid to 0, out_data0 to out_data3 to 0x00, and rr_ptr to 0, overriding any simultaneous accept or transfer.
REQ-026 SHALL keep in_ready and route combinationally derived during reset; route SHALL be 0 unless in_valid=1.
REQ-027 SHALL discard any byte held in a slot when reset is asserted mid-operation.

Configuration
REQ-023 SHALL, with macro MODE_DEMUX_SKIP_BUSY_EN defined, select in mode 1 the first free slot scanning rr_ptr, rr_ptr+1, ... mod 4, with in_ready=1 if any slot is free.
REQ-024 SHALL, without MODE_DEMUX_SKIP_BUSY_EN, select target = rr_ptr in mode 1 (strict rotation), stalling in_ready until that slot is free.

Verification
REQ-028 SHALL cover mode 0: in_dest=2, in_data=0xA5, all out_ready=0 -> next cycle out_valid=0100, out_data2=0xA5; a second byte to dest 2 -> in_ready=0.
REQ-029 SHALL cover mode 1: bytes 0x10, 0x11, 0x12, 0x13, 0x14 with all out_ready=1 -> routes 0001, 0010, 0100, 1000, 0001; rr_ptr 0, 1, 2, 3, 0.
REQ-030 SHALL cover mode 1 with out_valid[1]=1, out_ready[1]=0, rr_ptr=1 -> with SKIP_BUSY_EN route=0100, rr_ptr becomes 3; without it, in_ready=0 and rr_ptr stays 1.
REQ-031 SHALL cover the same-cycle drain and refill: channel 0 full, out_ready[0]=1, mode 0 byte 0x7E to dest 0 -> out_valid[0] stays 1, out_data0=0x7E.
REQ-032 SHALL cover rst=1 with all slots full and in_valid=1 -> next cycle out_valid=0000, all data 0x00, rr_ptr=0.
